alu_seq: RTL
============

Name: alu_seq

Overview:
- Clocked, parametrised successor to the microcontroller's bus-attached ALU.
- Operands are latched from the shared data bus, and an operation is launched with a start strobe.
- Single-cycle ops complete in one clock. An optional iterative multiply takes WIDTH clocks.
- The result is held in a register and driven back onto the bus on request. Status flags (Z, N, C, V) feed the branch unit.

Parameters:
- WIDTH, 16, datapath and bus width in bits (>= 4, power of two).
- SHW, $clog2(WIDTH), shift-amount field width, taken from in2[SHW-1:0] (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bus  inout  WIDTH  shared data bus; sampled on operand loads, driven when out_en=1.
- en_in1  in  1  load operand A from bus at this edge.
- en_in2  in  1  load operand B from bus at this edge.
- op_code  in  4  operation select, sampled with start.
- start  in  1  launch operation (one-cycle strobe).
- out_en  in  1  drive result register onto bus, else high-Z.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse: result and flags updated.
- flags  out  4  {Z,N,C,V}, registered.

Behaviour:
- Reset: in1, in2, result and flags clear to 0; busy=0, done=0; FSM goes to IDLE. Reset mid-multiply aborts it with no done pulse.
- Bus: bus = out_en ? result : 'z. This is combinational from the result register.
- Operand loads:
  - en_in1 and en_in2 are synchronous and may assert together; both then load the same bus value.
  - Loads are ignored while busy=1.
- Opcodes:
  - ADD=0, SUB=1, NOT=2 (~in1), AND=3, OR=4, XOR=5, XNOR=6, ADDI=7 (same as ADD), SUBI=8 (same as SUB).
  - SHL=9, SHR=10 (logical), SRA=11 (arithmetic). Shift amount is in2[SHW-1:0].
  - MUL=12: unsigned; result is the low WIDTH bits of the product.
  - 13..15: result 0.
- FSM: IDLE, MUL_RUN.
  - IDLE, start=1, non-MUL op: result and flags register at that edge; done=1 for the next cycle; stay IDLE.
  - IDLE, start=1, MUL: busy=1 and step counter=0 at that edge; go to MUL_RUN.
  - MUL_RUN: one shift-add step per clock.
  - MUL_RUN, after the WIDTH-th step: result and flags written, busy=0, done=1; return to IDLE.
  - Latency from the start edge to the done edge is WIDTH clocks.
  - start while busy: ignored, not queued.
  - start in the done cycle: accepted normally (back-to-back).
- Flags (updated only when done asserts):
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C:
    - ADD/ADDI: carry-out.
    - SUB/SUBI: borrow (1 iff in1<in2 unsigned).
    - Shifts: last bit shifted out, 0 if amount=0.
    - MUL: 1 iff the high half of the product is nonzero.
    - Otherwise 0.
  - V: signed overflow for ADD/SUB/ADDI/SUBI, otherwise 0.
- Arithmetic: all ops are modulo 2^WIDTH. Operands are held stable during MUL because loads are blocked.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL is the iterative multiplier described above; the MUL_RUN state and multiplier exist.
- Undefined: opcode 12 behaves like 13..15 (result 0, Z=1, others 0), completes single-cycle, and busy is tied 0.

Decomposition:
- Package alu_pkg:
  - opcode constants (ADD..MUL).
  - flag bit indices: Z=3, N=2, C=1, V=0.
  - FSM state encodings.
- Sub-module alu_mul_iter: shift-add unsigned multiplier with start/busy/done and a 2*WIDTH product output. Instantiated only under ALU_SEQ_MUL_EN.

Test Plan (WIDTH=16):
- Load A=0x7FFF, B=0x0001; ADD start → next cycle done=1; result=0x8000; flags Z=0, N=1, C=0, V=1; out_en=1 gives bus=0x8000 and 0 gives high-Z.
- A=0x0003, B=0x0005; SUB → result=0xFFFE, C=1, N=1, V=0. Then A=B=0x1234; XOR → result=0, Z=1.
- A=0x8001, B=0x0001: SRA → 0xC000, C=1; SHR → 0x4000, C=1; SHL → 0x0002, C=1. B=0x0000, SHL → 0x8001, C=0.
- MUL (macro on): A=0x0100, B=0x0101; start → busy high 16 cycles, done at the 16th edge; result=0x0100, C=1. A second start and en_in1 mid-run are ignored, and the operands are unchanged.
- MUL start; assert rst at cycle 5 → busy=0, no done pulse, result/flags/in1/in2=0. Then ADD 2+3 → 5, done after one cycle.
- Macro off: MUL 0x0002×0x0003 → single-cycle done, result=0, Z=1, busy never asserted. Back-to-back ADD starts on consecutive cycles → two consecutive done pulses.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, flag bit positions,
// FSM state encodings and a helper that packs the status flags.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd2;
    localparam logic [OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 4'd6;
    localparam logic [OP_W-1:0] OP_ADDI = 4'd7;
    localparam logic [OP_W-1:0] OP_SUBI = 4'd8;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd9;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd10;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd11;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd12;

    // Flag vector layout {Z,N,C,V}
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MUL_RUN = 1'b1;

    // Pack individual status bits into the {Z,N,C,V} vector
    function automatic logic [3:0] make_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_start       - launch; operands sampled at this edge (ignored while busy)
//   i_a, i_b      - WIDTH-bit unsigned operands
//   o_busy        - registered, high while steps remain
//   o_done_c      - combinational, high in the cycle whose closing edge runs the last step
//   o_product_c   - combinational 2*WIDTH product as it will be after the next step;
//                   equals the full product while o_done_c is high
module alu_mul_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done_c,
    output logic [2*WIDTH-1:0] o_product_c
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_acc_nxt;

    // Partial product for the current multiplier bit
    assign w_addend    = r_mplier[0] ? r_mcand : '0;
    assign w_acc_nxt   = r_acc + w_addend;

    assign o_busy      = r_busy;
    assign o_done_c    = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_product_c = w_acc_nxt;

    // Step registers; the start edge only loads, steps run on the following WIDTH edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_acc    <= '0;
            r_mcand  <= PW'(i_a);
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[PW-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
            if (o_done_c) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked bus-attached ALU: operands latched from the shared bus, operation
// launched by a start strobe, result held and driven back on request,
// {Z,N,C,V} status flags for the branch unit.
// Build option: define ALU_SEQ_MUL_EN to include the iterative multiplier
// (opcode 12, WIDTH-clock latency); otherwise opcode 12 yields 0 in one cycle.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   bus               - shared data bus; sampled on loads, driven when out_en=1
//   en_in1, en_in2    - load operand A / B from bus at this edge (blocked while busy)
//   op_code           - operation select, sampled with start
//   start             - one-cycle launch strobe
//   out_en            - drive result register onto bus, else high-Z
//   busy              - multi-cycle operation in progress
//   done              - one-cycle pulse when result and flags update
//   flags             - registered {Z,N,C,V}
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             en_in1,
    input  logic             en_in2,
    input  logic [3:0]       op_code,
    input  logic             start,
    input  logic             out_en,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_in1;
    logic [WIDTH-1:0] r_in2;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_done;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_in1_nxt;
    logic [WIDTH-1:0] w_in2_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic [3:0]       w_flags_nxt;
    logic             w_done_nxt;
    logic             w_load_ok;

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic [3:0]       w_alu_flags;

`ifdef ALU_SEQ_MUL_EN
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done_c;
    logic [2*WIDTH-1:0] w_mul_prod_c;
    logic [3:0]         w_mul_flags;

    alu_mul_iter #(
        .WIDTH       (WIDTH)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_mul_start),
        .i_a         (r_in1),
        .i_b         (r_in2),
        .o_busy      (w_mul_busy),
        .o_done_c    (w_mul_done_c),
        .o_product_c (w_mul_prod_c)
    );

    // Carry reports a nonzero high half of the full product
    assign w_mul_flags = make_flags(w_mul_prod_c[WIDTH-1:0] == '0, w_mul_prod_c[MSB],
                                    |w_mul_prod_c[2*WIDTH-1:WIDTH], 1'b0);
    assign busy        = r_busy;
    assign w_load_ok   = !r_busy;
`else
    assign busy        = 1'b0;
    assign w_load_ok   = 1'b1;
`endif

    assign bus   = out_en ? r_result : 'z;
    assign done  = r_done;
    assign flags = r_flags;

    assign w_shamt = r_in2[SHW-1:0];

    // Single-cycle datapath; shifts run one bit wider so the carry falls out of the extra bit
    always_comb begin
        w_ext     = '0;
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (op_code)
            OP_ADD, OP_ADDI: begin
                w_ext     = {1'b0, r_in1} + {1'b0, r_in2};
                w_alu_res = w_ext[WIDTH-1:0];
                w_alu_c   = w_ext[WIDTH];
                w_alu_v   = (r_in1[MSB] == r_in2[MSB]) && (w_alu_res[MSB] != r_in1[MSB]);
            end
            OP_SUB, OP_SUBI: begin
                // Bit WIDTH of the extended difference is the unsigned borrow
                w_ext     = {1'b0, r_in1} - {1'b0, r_in2};
                w_alu_res = w_ext[WIDTH-1:0];
                w_alu_c   = w_ext[WIDTH];
                w_alu_v   = (r_in1[MSB] != r_in2[MSB]) && (w_alu_res[MSB] != r_in1[MSB]);
            end
            OP_NOT:  w_alu_res = ~r_in1;
            OP_AND:  w_alu_res = r_in1 & r_in2;
            OP_OR:   w_alu_res = r_in1 | r_in2;
            OP_XOR:  w_alu_res = r_in1 ^ r_in2;
            OP_XNOR: w_alu_res = ~(r_in1 ^ r_in2);
            OP_SHL: begin
                w_ext     = {1'b0, r_in1} << w_shamt;
                w_alu_res = w_ext[WIDTH-1:0];
                w_alu_c   = w_ext[WIDTH];
            end
            OP_SHR: begin
                w_ext     = {r_in1, 1'b0} >> w_shamt;
                w_alu_res = w_ext[WIDTH:1];
                w_alu_c   = w_ext[0];
            end
            OP_SRA: begin
                w_ext     = (WIDTH+1)'($signed({r_in1, 1'b0}) >>> w_shamt);
                w_alu_res = w_ext[WIDTH:1];
                w_alu_c   = w_ext[0];
            end
            default: begin
                w_alu_res = '0;
            end
        endcase
    end

    assign w_alu_flags = make_flags(w_alu_res == '0, w_alu_res[MSB], w_alu_c, w_alu_v);

    // Next-state and register-update logic
    always_comb begin
        w_state_nxt  = r_state;
        w_in1_nxt    = r_in1;
        w_in2_nxt    = r_in2;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;
        w_done_nxt   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_busy_nxt   = r_busy;
        w_mul_start  = 1'b0;
`endif

        // Operands stay frozen during a multiply
        if (w_load_ok) begin
            if (en_in1) w_in1_nxt = bus;
            if (en_in2) w_in2_nxt = bus;
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op_code == OP_MUL) begin
                        w_mul_start = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_MUL_RUN;
                    end else
`endif
                    begin
                        w_result_nxt = w_alu_res;
                        w_flags_nxt  = w_alu_flags;
                        w_done_nxt   = 1'b1;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL_RUN: begin
                if (w_mul_done_c) begin
                    w_result_nxt = w_mul_prod_c[WIDTH-1:0];
                    w_flags_nxt  = w_mul_flags;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else if (!w_mul_busy) begin
                    // Multiplier not running: recover rather than hang
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_in1    <= '0;
            r_in2    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_busy   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_in1    <= w_in1_nxt;
            r_in2    <= w_in2_nxt;
            r_result <= w_result_nxt;
            r_flags  <= w_flags_nxt;
            r_done   <= w_done_nxt;
`ifdef ALU_SEQ_MUL_EN
            r_busy   <= w_busy_nxt;
`endif
        end
    end

endmodule
